// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, pipeline control and interrupt handshake out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             MemRead_EX;
  logic [1:0]       Rd_EX;
  logic [1:0]       Rs_ID;
  logic [1:0]       Rt_ID;
  logic             UseRs_ID;
  logic             UseRt_ID;
  logic             MemAccess_MEM;
  logic             BranchTaken_EX;
  logic             IntReq;
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             MemSel;
  logic             PC_Src_Int;
  logic             IntAck;
  logic [CNT_W-1:0] StallCount;

  // Pipeline side: drives status, receives control
  modport master (
    output MemRead_EX, Rd_EX, Rs_ID, Rt_ID, UseRs_ID, UseRt_ID,
           MemAccess_MEM, BranchTaken_EX, IntReq,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MemSel,
           PC_Src_Int, IntAck, StallCount
  );

  // Controller side
  modport slave (
    input  MemRead_EX, Rd_EX, Rs_ID, Rt_ID, UseRs_ID, UseRt_ID,
           MemAccess_MEM, BranchTaken_EX, IntReq,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MemSel,
           PC_Src_Int, IntAck, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: load-use stalls, shared-memory
// arbitration, branch flushes, interrupt entry and a saturating stall counter.
// Pipeline-control outputs are combinational so hazards resolve in-cycle.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz_if
);

  localparam int unsigned      DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    VEC   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             lockout_q, lockout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_flush_c;
  logic mem_sel_c, pc_src_int_c, int_ack_c;
  logic load_use_c, accept_c;

  // Load-use hazard: ID consumes a register the load in EX has not produced yet
  assign load_use_c = hz_if.MemRead_EX &
                      ((hz_if.UseRs_ID & (hz_if.Rs_ID == hz_if.Rd_EX)) |
                       (hz_if.UseRt_ID & (hz_if.Rt_ID == hz_if.Rd_EX)));

  // Interrupt taken only on a quiet RUN cycle; branch/load-use cycles defer it
  assign accept_c = (state_q == RUN) & hz_if.IntReq & ~lockout_q &
                    ~hz_if.BranchTaken_EX & ~load_use_c;

  // State, drain counter, lockout and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      drain_q   <= '0;
      lockout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      lockout_q <= lockout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state and pipeline-control decode
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    lockout_d     = lockout_q;
    cnt_d         = cnt_q;
    pc_write_c    = 1'b1;
    if_id_write_c = 1'b1;
    if_id_flush_c = 1'b0;
    id_ex_flush_c = 1'b0;
    mem_sel_c     = hz_if.MemAccess_MEM;
    pc_src_int_c  = 1'b0;
    int_ack_c     = 1'b0;

    case (state_q)
      RUN: begin
        lockout_d = 1'b0;
        if (hz_if.BranchTaken_EX) begin
          if_id_flush_c = 1'b1;
          id_ex_flush_c = 1'b1;
          pc_write_c    = 1'b1;
        end else if (load_use_c) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          id_ex_flush_c = 1'b1;
        end else if (hz_if.MemAccess_MEM) begin
          pc_write_c    = 1'b0;
          if_id_flush_c = 1'b1;
        end

        // Hold PC as the return address and start draining
        if (accept_c) begin
          pc_write_c    = 1'b0;
          if_id_flush_c = 1'b1;
          state_d       = DRAIN;
          drain_d       = DRAIN_LOAD;
        end

        if (!hz_if.BranchTaken_EX && !pc_write_c &&
            !(accept_c && hz_if.MemAccess_MEM) && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DRAIN: begin
        pc_write_c    = 1'b0;
        if_id_flush_c = 1'b1;
        if (drain_q == '0) begin
          state_d = VEC;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end

      VEC: begin
        mem_sel_c     = 1'b0;
        pc_src_int_c  = 1'b1;
        pc_write_c    = 1'b1;
        if_id_flush_c = 1'b1;
        int_ack_c     = 1'b1;
        state_d       = RUN;
        lockout_d     = 1'b1;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    // Reset freezes the front end and bubbles the pipeline
    if (rst) begin
      pc_write_c    = 1'b0;
      if_id_write_c = 1'b0;
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      mem_sel_c     = 1'b0;
      pc_src_int_c  = 1'b0;
      int_ack_c     = 1'b0;
    end
  end

  assign hz_if.PC_Write    = pc_write_c;
  assign hz_if.IF_ID_Write = if_id_write_c;
  assign hz_if.IF_ID_Flush = if_id_flush_c;
  assign hz_if.ID_EX_Flush = id_ex_flush_c;
  assign hz_if.MemSel      = mem_sel_c;
  assign hz_if.PC_Src_Int  = pc_src_int_c;
  assign hz_if.IntAck      = int_ack_c;
  assign hz_if.StallCount  = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: cycle-by-cycle reference model plus directed vectors
// with literal expectations. A second instance with a 3-bit counter covers saturation.
module tb_hazard_ctrl;

  localparam int unsigned D = 2;

  logic clk = 1'b0;
  logic rst;
  logic mr, urs, urt, mem, br, irq;
  logic [1:0] rd, rs, rt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) ifa ();
  hazard_ctrl_if #(.CNT_W(3))  ifb ();

  assign ifa.MemRead_EX = mr;  assign ifb.MemRead_EX = mr;
  assign ifa.Rd_EX = rd;       assign ifb.Rd_EX = rd;
  assign ifa.Rs_ID = rs;       assign ifb.Rs_ID = rs;
  assign ifa.Rt_ID = rt;       assign ifb.Rt_ID = rt;
  assign ifa.UseRs_ID = urs;   assign ifb.UseRs_ID = urs;
  assign ifa.UseRt_ID = urt;   assign ifb.UseRt_ID = urt;
  assign ifa.MemAccess_MEM = mem;   assign ifb.MemAccess_MEM = mem;
  assign ifa.BranchTaken_EX = br;   assign ifb.BranchTaken_EX = br;
  assign ifa.IntReq = irq;     assign ifb.IntReq = irq;

  hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz_if(ifa));
  hazard_ctrl #(.DRAIN_CYCLES(D), .CNT_W(3))  dut3 (.clk(clk), .rst(rst), .hz_if(ifb));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: interrupt sequence tracked by cycle offset from acceptance
  int  cyc        = 0;
  bit  in_seq     = 0;
  int  accept_at  = 0;
  int  lock_cycle = -1;
  int  m_cnt16    = 0;
  int  m_cnt3     = 0;

  always @(negedge clk) begin
    bit e_pcw, e_ifw, e_iff, e_idf, e_ms, e_psi, e_ack;
    bit lu, acc;
    int off;
    e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_ms = mem; e_psi = 0; e_ack = 0;
    lu  = mr && ((urs && rs == rd) || (urt && rt == rd));
    acc = 0;
    if (rst) begin
      e_pcw = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_ms = 0;
    end else if (in_seq) begin
      off = cyc - accept_at;
      if (off <= int'(D)) begin
        e_pcw = 0; e_iff = 1;
      end else begin
        e_ms = 0; e_psi = 1; e_iff = 1; e_ack = 1;
      end
    end else begin
      if (br) begin
        e_iff = 1; e_idf = 1;
      end else if (lu) begin
        e_pcw = 0; e_ifw = 0; e_idf = 1;
      end else if (mem) begin
        e_pcw = 0; e_iff = 1;
      end
      acc = irq && (cyc != lock_cycle) && !br && !lu;
      if (acc) begin e_pcw = 0; e_iff = 1; end
    end

    chk("PC_Write",    32'(ifa.PC_Write),    32'(e_pcw));
    chk("IF_ID_Write", 32'(ifa.IF_ID_Write), 32'(e_ifw));
    chk("IF_ID_Flush", 32'(ifa.IF_ID_Flush), 32'(e_iff));
    chk("ID_EX_Flush", 32'(ifa.ID_EX_Flush), 32'(e_idf));
    chk("MemSel",      32'(ifa.MemSel),      32'(e_ms));
    chk("PC_Src_Int",  32'(ifa.PC_Src_Int),  32'(e_psi));
    chk("IntAck",      32'(ifa.IntAck),      32'(e_ack));
    chk("StallCount",  32'(ifa.StallCount),  32'(m_cnt16));
    chk("StallCount3", 32'(ifb.StallCount),  32'(m_cnt3));
    chk("IntAck3",     32'(ifb.IntAck),      32'(e_ack));

    // Advance the model to the state seen after the coming rising edge
    if (rst) begin
      in_seq = 0; lock_cycle = -1; m_cnt16 = 0; m_cnt3 = 0;
    end else if (in_seq) begin
      if (cyc - accept_at == int'(D) + 1) begin
        in_seq = 0;
        lock_cycle = cyc + 1;
      end
    end else begin
      if (!br && !e_pcw && !(acc && mem)) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (acc) begin in_seq = 1; accept_at = cyc; end
    end
    cyc++;
  end

  // Inputs change 1 time unit after the rising edge; literal checks follow 2 units later
  task automatic set_in(input bit r, input bit i_mr, input logic [1:0] i_rd,
                        input logic [1:0] i_rs, input logic [1:0] i_rt,
                        input bit i_urs, input bit i_urt, input bit i_mem,
                        input bit i_br, input bit i_irq);
    rst = r; mr = i_mr; rd = i_rd; rs = i_rs; rt = i_rt;
    urs = i_urs; urt = i_urt; mem = i_mem; br = i_br; irq = i_irq;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit i_irq);
    set_in(0, 0, 2'd0, 2'd1, 2'd1, 0, 0, 0, 0, i_irq);
  endtask

  initial begin
    rst = 1; mr = 0; rd = 0; rs = 0; rt = 0; urs = 0; urt = 0; mem = 0; br = 0; irq = 0;
    tick();
    set_in(1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    chk("rst_pcw", 32'(ifa.PC_Write), 32'd0);
    chk("rst_iff", 32'(ifa.IF_ID_Flush), 32'd1);
    tick();

    idle(0);
    chk("lit_cnt0", 32'(ifa.StallCount), 32'd0);
    chk("lit_idle_pcw", 32'(ifa.PC_Write), 32'd1);
    tick();

    // Load-use on Rs
    set_in(0, 1, 2'd2, 2'd2, 2'd0, 1, 0, 0, 0, 0);
    chk("lit_lu_pcw", 32'(ifa.PC_Write), 32'd0);
    chk("lit_lu_ifw", 32'(ifa.IF_ID_Write), 32'd0);
    chk("lit_lu_idf", 32'(ifa.ID_EX_Flush), 32'd1);
    tick();
    // Same registers but Rs not used
    set_in(0, 1, 2'd2, 2'd2, 2'd0, 0, 0, 0, 0, 0);
    chk("lit_cnt1", 32'(ifa.StallCount), 32'd1);
    chk("lit_nolu_pcw", 32'(ifa.PC_Write), 32'd1);
    tick();
    // Load-use on Rt
    set_in(0, 1, 2'd3, 2'd0, 2'd3, 0, 1, 0, 0, 0);
    chk("lit_lurt_pcw", 32'(ifa.PC_Write), 32'd0);
    tick();

    // Structural only
    set_in(0, 0, 2'd0, 2'd1, 2'd1, 0, 0, 1, 0, 0);
    chk("lit_st_ms", 32'(ifa.MemSel), 32'd1);
    chk("lit_st_pcw", 32'(ifa.PC_Write), 32'd0);
    chk("lit_st_iff", 32'(ifa.IF_ID_Flush), 32'd1);
    chk("lit_st_ifw", 32'(ifa.IF_ID_Write), 32'd1);
    tick();
    // Load-use plus structural
    set_in(0, 1, 2'd1, 2'd1, 2'd0, 1, 0, 1, 0, 0);
    chk("lit_lust_ifw", 32'(ifa.IF_ID_Write), 32'd0);
    chk("lit_lust_iff", 32'(ifa.IF_ID_Flush), 32'd0);
    chk("lit_lust_ms", 32'(ifa.MemSel), 32'd1);
    tick();
    // Branch masks load-use and structural
    set_in(0, 1, 2'd1, 2'd1, 2'd0, 1, 0, 1, 1, 0);
    chk("lit_cnt4", 32'(ifa.StallCount), 32'd4);
    chk("lit_br_iff", 32'(ifa.IF_ID_Flush), 32'd1);
    chk("lit_br_idf", 32'(ifa.ID_EX_Flush), 32'd1);
    chk("lit_br_pcw", 32'(ifa.PC_Write), 32'd1);
    tick();
    idle(0);
    chk("lit_cnt4b", 32'(ifa.StallCount), 32'd4);
    tick();

    // Clean interrupt held through two acknowledges
    idle(1);
    chk("lit_acc_pcw", 32'(ifa.PC_Write), 32'd0);
    chk("lit_acc_iff", 32'(ifa.IF_ID_Flush), 32'd1);
    tick();
    set_in(0, 0, 2'd0, 2'd1, 2'd1, 0, 0, 1, 0, 1);
    chk("lit_drain_ms", 32'(ifa.MemSel), 32'd1);
    tick();
    idle(1); tick();
    idle(1);
    chk("lit_vec_ack", 32'(ifa.IntAck), 32'd1);
    chk("lit_vec_psi", 32'(ifa.PC_Src_Int), 32'd1);
    chk("lit_vec_ms", 32'(ifa.MemSel), 32'd0);
    tick();
    idle(1);
    chk("lit_lock_pcw", 32'(ifa.PC_Write), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin idle(1); tick(); end
    idle(1);
    chk("lit_reack", 32'(ifa.IntAck), 32'd1);
    tick();
    idle(0); tick();
    idle(0); tick();

    // Deferral behind a branch, acceptance with a data access
    set_in(0, 0, 2'd0, 2'd1, 2'd1, 0, 0, 0, 1, 1);
    chk("lit_def_pcw", 32'(ifa.PC_Write), 32'd1);
    tick();
    set_in(0, 0, 2'd0, 2'd1, 2'd1, 0, 0, 1, 0, 1);
    chk("lit_def_acc", 32'(ifa.PC_Write), 32'd0);
    chk("lit_def_ms", 32'(ifa.MemSel), 32'd1);
    tick();
    idle(1); tick();
    idle(1); tick();
    idle(1);
    chk("lit_def_ack", 32'(ifa.IntAck), 32'd1);
    tick();
    idle(0); tick();

    // Reset during DRAIN
    idle(1); tick();
    set_in(1, 0, 2'd0, 2'd1, 2'd1, 0, 0, 0, 0, 0);
    tick();
    idle(0);
    chk("lit_rst_ack", 32'(ifa.IntAck), 32'd0);
    chk("lit_rst_pcw", 32'(ifa.PC_Write), 32'd1);
    chk("lit_rst_cnt", 32'(ifa.StallCount), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin idle(0); tick(); end

    // Saturation: nine structural stalls
    for (int i = 0; i < 9; i++) begin
      set_in(0, 0, 2'd0, 2'd1, 2'd1, 0, 0, 1, 0, 0);
      tick();
    end
    idle(0);
    chk("lit_sat3", 32'(ifb.StallCount), 32'd7);
    chk("lit_cnt9", 32'(ifa.StallCount), 32'd9);
    tick();
    idle(0); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 4-register, 5-stage pipelined core. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve: load-use stalls, the structural conflict on the single shared instruction/data memory, taken-branch flushes and interrupt entry. It also counts stall cycles for performance measurement. Only the interrupt state machine and the counter are registered; all pipeline-control outputs are combinational from state and current-cycle inputs.

## Interface
- DRAIN_CYCLES, 2: DRAIN cycles after interrupt acceptance before the vector fetch; must be ≥1.
- CNT_W, 16: StallCount width.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead_EX  in  1  instruction in EX is a load.
- Rd_EX  in  2  destination register of the instruction in EX.
- Rs_ID  in  2  source register 1 of the instruction in ID.
- Rt_ID  in  2  source register 2 of the instruction in ID.
- UseRs_ID  in  1  instruction in ID reads Rs.
- UseRt_ID  in  1  instruction in ID reads Rt.
- MemAccess_MEM  in  1  instruction in MEM reads or writes data memory.
- BranchTaken_EX  in  1  branch/jump in EX resolved taken.
- IntReq  in  1  level interrupt request; held until IntAck.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID load enable.
- IF_ID_Flush  out  1  load NOP into IF/ID; overrides IF_ID_Write.
- ID_EX_Flush  out  1  load NOP into ID/EX (bubble).
- MemSel  out  1  shared-memory owner: 0 = fetch, 1 = data port.
- PC_Src_Int  out  1  PC loads the vector word read from memory.
- IntAck  out  1  one-cycle interrupt acknowledge.
- StallCount  out  CNT_W  saturating count of RUN-state stall cycles.

## Operation
- States: RUN, DRAIN, VEC. After reset: RUN, StallCount=0, lockout=0, drain counter=0.
- While rst=1, outputs are PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, MemSel=0, PC_Src_Int=0, IntAck=0.
- Defaults in every state: PC_Write=1, IF_ID_Write=1, flushes=0, PC_Src_Int=0, IntAck=0, and MemSel=MemAccess_MEM. Data access always wins the memory.
- The RUN state evaluates the following in priority order:
  - BranchTaken_EX: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1. This masks any load-use or structural stall in the same cycle.
  - Load-use, defined as MemRead_EX & ((UseRs_ID & Rs_ID==Rd_EX) | (UseRt_ID & Rt_ID==Rd_EX)): PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - MemAccess_MEM alone: PC_Write=0, IF_ID_Flush=1. Fetch is lost that cycle, so IF/ID receives a NOP.
- StallCount increments on each RUN cycle with PC_Write=0 and no branch, and saturates at all-ones.
- Interrupt acceptance requires a RUN cycle with IntReq=1, lockout=0, no branch and no load-use.
  - An accepted cycle otherwise behaves as normal RUN, except PC_Write=0 and IF_ID_Flush=1. The held PC is the return address.
  - The state goes to DRAIN and the drain counter loads DRAIN_CYCLES-1.
  - An acceptance cycle with MemAccess_MEM=1 does not increment StallCount.
  - IntReq during a branch or load-use cycle is deferred, not dropped.
- DRAIN: PC_Write=0, IF_ID_Flush=1. The counter decrements each cycle; at 0 the state goes to VEC.
- VEC lasts one cycle with MemSel=0, PC_Src_Int=1, PC_Write=1, IF_ID_Flush=1 and IntAck=1. The state then goes to RUN and sets lockout=1.
  - Return-address saving on IntAck is handled outside this block.
- Lockout blocks acceptance for exactly the first RUN cycle after VEC, then clears.
- BranchTaken_EX and MemAccess_MEM are 0 in DRAIN/VEC by construction, because the pipeline has drained. If asserted anyway, MemSel still follows MemAccess_MEM in DRAIN, and the state machine ignores both.

## Timing
- Hazard outputs have zero latency: they respond in the same cycle as their inputs.
- Interrupt sequence with acceptance at T and DRAIN_CYCLES=2:
  - T: accept.
  - T+1, T+2: DRAIN.
  - T+3: VEC (IntAck).
  - T+4: RUN, with lockout active.
- Interrupt latency is DRAIN_CYCLES+1 cycles from acceptance to IntAck.
- StallCount and state update at the edge ending the cycle. StallCount is visible the next cycle.
- Reset in DRAIN or VEC gives RUN on the next cycle with no IntAck and counters cleared. rst overrides every event in the same cycle.

## Test plan
- Load-use: MemRead_EX=1, Rd_EX=2, Rs_ID=2, UseRs_ID=1 → same cycle PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount 0→1. Repeat with UseRs_ID=0 → no stall.
- Structural: MemAccess_MEM=1 only → MemSel=1, PC_Write=0, IF_ID_Flush=1, IF_ID_Write=1. Then a load-use plus MemAccess_MEM cycle → IF_ID_Write=0, IF_ID_Flush=0, MemSel=1.
- Branch priority: BranchTaken_EX=1 with an active load-use and MemAccess_MEM=1 → both flushes=1, PC_Write=1, StallCount unchanged.
- Interrupt: IntReq=1 at T (clean) → T: PC_Write=0, IF_ID_Flush=1; T+3: PC_Src_Int=1, IntAck=1, MemSel=0; IntReq still 1 at T+4 is ignored; IntAck re-pulses at T+8 if IntReq is still held.
- Deferral/reset: IntReq with BranchTaken_EX at T → acceptance at T+1. rst asserted in DRAIN → RUN next cycle, no IntAck, StallCount=0.
- Saturation: CNT_W=3, 9 consecutive structural stalls → StallCount stops at 7.
